// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Provides the arbiter state enum, default sizes and a clog2 helper.
package rr_arb_pkg;

    localparam int ARB_N_DEF  = 4;
    localparam int ARB_WW_DEF = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search over req starting at ptr (modulo N).
// Ports: req/ptr in; found (any req set) and idx (winner) out.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N  = ARB_N_DEF,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int k;

    assign found = |req;

    // Walk offsets high to low so the smallest offset from ptr wins.
    // The wrap is a subtract, so non-power-of-2 N stays in range.
    always_comb begin
        idx = '0;
        k   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (req[IW'(k)]) idx = IW'(k);
        end
    end

endmodule

// File: rtl/rr_arbiter_wrr.sv
// Weighted round-robin arbiter with registered one-hot grant.
// Ports: clk, rst; REQ, WEIGHT, LOCK in; GNT, GNT_ID, GNT_VALID out.
module rr_arbiter_wrr
    import rr_arb_pkg::*;
#(
    parameter  int N  = ARB_N_DEF,
    parameter  int WW = ARB_WW_DEF,
    localparam int IW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    REQ,
    input  logic [N*WW-1:0] WEIGHT,
    input  logic            LOCK,
    output logic [N-1:0]    GNT,
    output logic [IW-1:0]   GNT_ID,
    output logic            GNT_VALID
);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [WW-1:0] credit;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] pick_next;
    logic [WW-1:0] pick_wt;
    logic [WW-1:0] pick_credit;
    logic          owner_req;
    logic          take;
    logic          drop;
    logic          dec;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_wt = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) pick_wt = WEIGHT[i*WW +: WW];
        end
    end

    // Weight 0 behaves as 1: the grant cycle itself is the whole burst.
    assign pick_credit = (pick_wt == '0) ? '0 : pick_wt - 1'b1;
    assign pick_next   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
    assign owner_req   = REQ[GNT_ID];

    // Early release beats LOCK; LOCK beats credit countdown.
    always_comb begin
        take = 1'b0;
        drop = 1'b0;
        dec  = 1'b0;
        unique case (state)
            ARB_IDLE: take = pick_found;
            ARB_GRANT: begin
                if (!owner_req) begin
                    take = pick_found;
                    drop = !pick_found;
                end else if (!LOCK) begin
                    if (credit != '0) dec  = 1'b1;
                    else              take = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            credit    <= '0;
            GNT       <= '0;
            GNT_ID    <= '0;
            GNT_VALID <= 1'b0;
        end else if (take) begin
            state     <= ARB_GRANT;
            ptr       <= pick_next;
            credit    <= pick_credit;
            GNT       <= N'(1) << pick_idx;
            GNT_ID    <= pick_idx;
            GNT_VALID <= 1'b1;
        end else if (drop) begin
            state     <= ARB_IDLE;
            credit    <= '0;
            GNT       <= '0;
            GNT_ID    <= '0;
            GNT_VALID <= 1'b0;
        end else if (dec) begin
            credit    <= credit - 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_wrr.sv
// Directed bench for rr_arbiter_wrr with N=4, WW=4.
// Inputs change on the falling edge; outputs are checked there too.
module tb_rr_arbiter_wrr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  REQ;
    logic [15:0] WEIGHT;
    logic        LOCK;
    logic [3:0]  GNT;
    logic [1:0]  GNT_ID;
    logic        GNT_VALID;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter_wrr #(
        .N  (4),
        .WW (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .REQ       (REQ),
        .WEIGHT    (WEIGHT),
        .LOCK      (LOCK),
        .GNT       (GNT),
        .GNT_ID    (GNT_ID),
        .GNT_VALID (GNT_VALID)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] oh_id(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_gnt(input string tag, input logic [3:0] g);
        chk({tag, ".gnt"},   32'(GNT),       32'(g));
        chk({tag, ".id"},    32'(GNT_ID),    32'(oh_id(g)));
        chk({tag, ".valid"}, 32'(GNT_VALID), 32'(g != 4'b0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk_gnt("rst", 4'b0000);
        rst = 1'b0;
    endtask

    logic [3:0] seq2 [5];
    logic [3:0] seq3 [10];

    initial begin
        seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0010};

        rst    = 1'b1;
        REQ    = 4'b1111;
        WEIGHT = 16'h1111;
        LOCK   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_gnt($sformatf("hold%0d", i), 4'b0000);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt($sformatf("rr%0d", i), seq2[i]);
        end

        do_reset();
        WEIGHT = 16'h1302;
        REQ    = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_gnt($sformatf("wrr%0d", i), seq3[i]);
        end

        do_reset();
        WEIGHT = 16'h1311;
        REQ    = 4'b1100;
        tick();
        chk_gnt("early.own", 4'b0100);
        REQ = 4'b1000;
        tick();
        chk_gnt("early.next", 4'b1000);
        tick();
        chk_gnt("early.stay", 4'b1000);

        do_reset();
        WEIGHT = 16'h1111;
        REQ    = 4'b0011;
        tick();
        chk_gnt("lock.first", 4'b0001);
        LOCK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt($sformatf("lock%0d", i), 4'b0001);
        end
        LOCK = 1'b0;
        chk_gnt("lock.persist", 4'b0001);
        tick();
        chk_gnt("lock.after", 4'b0010);

        do_reset();
        REQ = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_gnt($sformatf("sole%0d", i), 4'b0100);
        end
        rst = 1'b1;
        tick();
        chk_gnt("midrst", 4'b0000);
        rst = 1'b0;
        REQ = 4'b1010;
        tick();
        chk_gnt("restart", 4'b0010);
        tick();
        chk_gnt("restart.next", 4'b1000);

        do_reset();
        REQ  = 4'b0000;
        LOCK = 1'b1;
        tick();
        chk_gnt("idle.lock", 4'b0000);
        LOCK = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_wrr.md
Name: rr_arbiter_wrr

Overview:
Parametrised weighted round-robin arbiter for N requesters with a registered one-hot grant. It is the successor to the fixed 4-way round-robin arbiter.
- Each winner may hold the grant for up to WEIGHT[i] consecutive cycles (a credit burst).
- A LOCK input holds the current grant indefinitely.
- It sits in front of shared resources (bus, memory port) that need fair but weighted access.

Parameters:
N, 4, number of requesters (>=2; need not be a power of 2)
WW, 4, width of each per-requester weight field
IW, $clog2(N), width of GNT_ID (derived; not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
REQ  input  N  request vector, bit i = requester i
WEIGHT  input  N*WW  burst length per requester; field i = WEIGHT[i*WW +: WW]
LOCK  input  1  while high, current owner keeps the grant without consuming credit
GNT  output  N  registered one-hot grant, all-zero when idle
GNT_ID  output  IW  binary index of current owner (0 when idle)
GNT_VALID  output  1  high when GNT is non-zero

Behaviour:
- Reset (rst=1 at a rising edge; dominates all other inputs):
  - GNT=0, GNT_ID=0, GNT_VALID=0.
  - State IDLE, ptr=0, credit=0.
- Latency: REQ sampled at edge k is reflected in GNT after edge k. There is no combinational path from REQ to GNT.
- Pick function: first requester with REQ set, searching circularly from ptr upward (ptr, ptr+1, ..., N-1, 0, ...). Index wrap is modulo N, correct for non-power-of-2 N.
- New grant to index w:
  - GNT=onehot(w), GNT_ID=w, GNT_VALID=1.
  - ptr<=(w+1) mod N.
  - credit<=max(WEIGHT[w],1)-1. Weight 0 is treated as 1.
  - WEIGHT is sampled only at grant time; later changes do not affect the current burst.
- State IDLE:
  - REQ==0: stay IDLE, outputs zero.
  - Otherwise: new grant via pick, go to GRANT.
- State GRANT, owner o; priority order:
  1. REQ[o]==0 (early release): re-arbitrate at this same edge via pick from ptr. If REQ==0, go to IDLE and clear outputs. There is no dead cycle between owners.
  2. LOCK=1: hold GNT; credit unchanged.
  3. credit!=0: hold GNT; credit<=credit-1.
  4. credit==0 (burst exhausted): re-arbitrate via pick from ptr (=o+1). If o is the sole requester, it wins again with credit reloaded, and GNT stays continuously high.
- LOCK has no effect in IDLE and does not create a grant.
- GNT is always one-hot or zero. GNT_ID and GNT_VALID are consistent with GNT every cycle.
- Fairness: with all requesters continuously active and LOCK=0, each requester i receives exactly max(WEIGHT[i],1) cycles per rotation, in index order.
- Reset mid-burst: grant drops at that edge. After reset, arbitration restarts with ptr=0.

Decomposition:
- Package rr_arb_pkg:
  - state enum {ARB_IDLE, ARB_GRANT}
  - clog2 helper function
  - default N/WW constants
- Sub-module rr_pick (combinational):
  - inputs: req[N], ptr[IW]
  - outputs: found, idx[IW]
  - implemented as a rotate-and-priority-encode.
- The top level holds the state, ptr, credit and output registers.

Test Plan:
All cases use N=4, WW=4, with REQ/LOCK driven on the falling edge.
1. Reset hold: rst=1 for 3 cycles with REQ=1111 -> GNT=0000, GNT_VALID=0, GNT_ID=0 throughout.
2. Plain round robin: weights all 1, REQ=1111 -> GNT sequence 0001,0010,0100,1000,0001, one cycle each; GNT_ID 0,1,2,3,0.
3. Weighted bursts: WEIGHT fields {w3=1,w2=3,w1=0,w0=2}, REQ=1111 -> 0001 x2, 0010 x1 (weight 0 treated as 1), 0100 x3, 1000 x1, then the sequence repeats.
4. Early release: w2=3, REQ=1100 with owner 2. Drop REQ[2] after its first grant cycle -> GNT=1000 on the next edge, with no 0000 cycle in between.
5. Lock: REQ=0011, w0=1, LOCK=1 for 5 cycles once GNT=0001 -> GNT holds 0001 for 5 cycles. After LOCK falls, 0001 persists one more cycle, then GNT=0010.
6. Sole requester and reset mid-burst:
   - REQ=0100, w2=1 -> GNT=0100 continuously.
   - rst=1 for one edge -> GNT=0000.
   - After release with REQ=1010 -> first grant 0010 (ptr restarted at 0).
